// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: access-width encodings, wait-state FSM states and
// the store byte-lane mask helper.
package mips_pkg;

    localparam logic [1:0] LOAD_WORD  = 2'b00;
    localparam logic [1:0] LOAD_HALF  = 2'b01;
    localparam logic [1:0] LOAD_BYTE  = 2'b10;
    localparam logic [1:0] LOAD_BYTEU = 2'b11;

    typedef enum logic {
        IDLE,
        BUSY
    } mem_state_t;

    // Byte lanes touched by an access of the given width at byte offset lo.
    function automatic logic [3:0] lane_mask(input logic [1:0] mode, input logic [1:0] lo);
        logic [3:0] m;
        case (mode)
            LOAD_WORD: m = 4'b1111;
            LOAD_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
            default:   m = 4'b0001 << lo;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM-to-MEM/WB bus of the MEM stage: EX/MEM inputs, branch outputs, stall and the
// MEM/WB register outputs. The EX side is master, mem_stage is slave.
interface mem_stage_if;

    logic        reg_write_in;
    logic        mem_write_in;
    logic        mem_read_in;
    logic        mem_to_reg_in;
    logic [1:0]  load_mode_in;
    logic [4:0]  wb_dest_in;
    logic [31:0] alu_result_in;
    logic [31:0] rt_in;
    logic        branch_in;
    logic        zero_in;
    logic [31:0] branch_target_in;

    logic        pc_src;
    logic [31:0] branch_target;
    logic        stall;
    logic        MEM_WB_RegWrite;
    logic        MEM_WB_MemToReg;
    logic [31:0] MEM_WB_read_data;
    logic [31:0] MEM_WB_alu_result;
    logic [4:0]  MEM_WB_wb_dest;
    logic        misalign;

    modport master (
        output reg_write_in, mem_write_in, mem_read_in, mem_to_reg_in, load_mode_in,
               wb_dest_in, alu_result_in, rt_in, branch_in, zero_in, branch_target_in,
        input  pc_src, branch_target, stall, MEM_WB_RegWrite, MEM_WB_MemToReg,
               MEM_WB_read_data, MEM_WB_alu_result, MEM_WB_wb_dest, misalign
    );

    modport slave (
        input  reg_write_in, mem_write_in, mem_read_in, mem_to_reg_in, load_mode_in,
               wb_dest_in, alu_result_in, rt_in, branch_in, zero_in, branch_target_in,
        output pc_src, branch_target, stall, MEM_WB_RegWrite, MEM_WB_MemToReg,
               MEM_WB_read_data, MEM_WB_alu_result, MEM_WB_wb_dest, misalign
    );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Word-organised data memory with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module data_mem #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data memory access, branch resolve, wait-state FSM and MEM/WB register.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned MEM_WAIT = 0
) (
    input logic        CLK,
    input logic        RST_N,
    mem_stage_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    mem_state_t  state;
    logic [CW-1:0] cnt;

    logic        access;
    logic        stall_c;
    logic        misaligned;
    logic [1:0]  addr_lo;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] load_val;
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic        load_ok;

    assign bus.pc_src        = bus.branch_in & bus.zero_in;
    assign bus.branch_target = bus.branch_target_in;

    assign access = bus.mem_read_in | bus.mem_write_in;

    always_comb begin
        misaligned = 1'b0;
        addr_lo    = bus.alu_result_in[1:0];
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = ((bus.load_mode_in == LOAD_WORD) && (bus.alu_result_in[1:0] != 2'b00)) ||
                     ((bus.load_mode_in == LOAD_HALF) && bus.alu_result_in[0]);
`else
        if (bus.load_mode_in == LOAD_WORD)      addr_lo = 2'b00;
        else if (bus.load_mode_in == LOAD_HALF) addr_lo = {bus.alu_result_in[1], 1'b0};
`endif
    end

    // Stall is combinational so the access cycle itself stalls; reset drops it at once.
    assign stall_c = RST_N && (MEM_WAIT != 0) &&
                     (((state == IDLE) && access) || ((state == BUSY) && (cnt != '0)));
    assign bus.stall = stall_c;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if ((MEM_WAIT != 0) && access) begin
                    state <= BUSY;
                    cnt   <= CW'(MEM_WAIT - 1);
                end
                BUSY: if (cnt != '0) cnt <= cnt - 1'b1;
                      else           state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (bus.load_mode_in)
            LOAD_WORD: wdata = bus.rt_in;
            LOAD_HALF: wdata = {2{bus.rt_in[15:0]}};
            default:   wdata = {4{bus.rt_in[7:0]}};
        endcase
        we = '0;
        if (bus.mem_write_in && !stall_c && !misaligned && RST_N)
            we = lane_mask(bus.load_mode_in, addr_lo);
    end

    data_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (CLK),
        .we    (we),
        .addr  (bus.alu_result_in[AW+1:2]),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_comb begin
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        case (bus.load_mode_in)
            LOAD_WORD: load_val = rdata;
            LOAD_HALF: load_val = {{16{half_v[15]}}, half_v};
            LOAD_BYTE: load_val = {{24{byte_v[7]}}, byte_v};
            default:   load_val = {24'b0, byte_v};
        endcase
        load_ok = bus.mem_read_in && !bus.mem_write_in && !misaligned;
    end

    // Stalled cycles insert a bubble; the data fields simply hold.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.MEM_WB_RegWrite   <= 1'b0;
            bus.MEM_WB_MemToReg   <= 1'b0;
            bus.MEM_WB_read_data  <= '0;
            bus.MEM_WB_alu_result <= '0;
            bus.MEM_WB_wb_dest    <= '0;
            bus.misalign          <= 1'b0;
        end else if (stall_c) begin
            bus.MEM_WB_RegWrite <= 1'b0;
            bus.MEM_WB_MemToReg <= 1'b0;
            bus.misalign        <= 1'b0;
        end else begin
            bus.MEM_WB_RegWrite   <= bus.reg_write_in && !(misaligned && bus.mem_read_in);
            bus.MEM_WB_MemToReg   <= bus.mem_to_reg_in;
            bus.MEM_WB_read_data  <= load_ok ? load_val : '0;
            bus.MEM_WB_alu_result <= bus.alu_result_in;
            bus.MEM_WB_wb_dest    <= bus.wb_dest_in;
            bus.misalign          <= misaligned && access;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: single-cycle, 2-wait and 3-wait instances.
module tb_mem_stage;
    import mips_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] rd;
        logic [31:0] alu;
        logic        rw;
        logic        m2r;
        logic        mis;
        logic [4:0]  dest;
    } exp_t;

    logic CLK = 1'b0;
    logic rst_n, rst3_n;
    always #5 CLK = ~CLK;

    mem_stage_if b0 ();
    mem_stage_if bw2 ();
    mem_stage_if bw3 ();

    mem_stage #(.DEPTH(256), .MEM_WAIT(0)) u0 (.CLK(CLK), .RST_N(rst_n),  .bus(b0));
    mem_stage #(.DEPTH(256), .MEM_WAIT(2)) u2 (.CLK(CLK), .RST_N(rst_n),  .bus(bw2));
    mem_stage #(.DEPTH(256), .MEM_WAIT(3)) u3 (.CLK(CLK), .RST_N(rst3_n), .bus(bw3));

    exp_t q0[$];
    exp_t qw[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned op_id    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ctl(input logic mis, input logic rw, input logic m2r,
                                        input logic [4:0] dest);
        return {24'b0, mis, rw, m2r, dest};
    endfunction

    task automatic compare_out(input string tag, input exp_t e, input logic [31:0] rd,
                               input logic [31:0] alu, input logic [31:0] c);
        check({tag, ".data"}, rd, e.rd);
        check({tag, ".alu"},  alu, e.alu);
        check({tag, ".ctl"},  c, ctl(e.mis, e.rw, e.m2r, e.dest));
    endtask

    // Single-cycle instance: inputs presented after one edge, results after the next.
    task automatic issue0(input string tag, input logic rw, input logic rd, input logic wr,
                          input logic [1:0] mode, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] exp_rd, input logic exp_mis);
        exp_t e;
        op_id++;
        b0.reg_write_in = rw;  b0.mem_read_in = rd;  b0.mem_write_in = wr;
        b0.mem_to_reg_in = rd; b0.load_mode_in = mode; b0.alu_result_in = addr;
        b0.rt_in = rt;         b0.wb_dest_in = 5'(op_id);
        e = '{rd: exp_rd, alu: addr, rw: rw & ~(exp_mis & rd), m2r: rd, mis: exp_mis,
              dest: 5'(op_id)};
        q0.push_back(e);
        #1 check({tag, ".stall"}, 32'(b0.stall), 32'd0);
        @(posedge CLK); #1;
        e = q0.pop_front();
        compare_out(tag, e, b0.MEM_WB_read_data, b0.MEM_WB_alu_result,
                    ctl(b0.misalign, b0.MEM_WB_RegWrite, b0.MEM_WB_MemToReg, b0.MEM_WB_wb_dest));
    endtask

    // Two-wait instance: counts stall cycles, checks bubbles, optionally watches the word.
    task automatic issue_w(input string tag, input logic rw, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] rt,
                           input logic [31:0] exp_rd, input logic mem_chk,
                           input logic [31:0] old_w, input logic [31:0] new_w);
        exp_t e;
        int unsigned n = 0;
        op_id++;
        bw2.reg_write_in = rw;  bw2.mem_read_in = rd;  bw2.mem_write_in = wr;
        bw2.mem_to_reg_in = rd; bw2.load_mode_in = LOAD_WORD; bw2.alu_result_in = addr;
        bw2.rt_in = rt;         bw2.wb_dest_in = 5'(op_id);
        e = '{rd: exp_rd, alu: addr, rw: rw, m2r: rd, mis: 1'b0, dest: 5'(op_id)};
        qw.push_back(e);
        #1;
        while (bw2.stall && n < 20) begin
            if (mem_chk) check({tag, ".hold"}, u2.u_mem.mem[addr[9:2]], old_w);
            n++;
            @(posedge CLK); #1;
            check({tag, ".bubble"}, 32'({bw2.MEM_WB_RegWrite, bw2.MEM_WB_MemToReg}), 32'd0);
        end
        check({tag, ".waits"}, 32'(n), 32'd2);
        @(posedge CLK); #1;
        e = qw.pop_front();
        compare_out(tag, e, bw2.MEM_WB_read_data, bw2.MEM_WB_alu_result,
                    ctl(bw2.misalign, bw2.MEM_WB_RegWrite, bw2.MEM_WB_MemToReg,
                        bw2.MEM_WB_wb_dest));
        if (mem_chk) check({tag, ".commit"}, u2.u_mem.mem[addr[9:2]], new_w);
    endtask

    initial begin
        rst_n = 1'b0; rst3_n = 1'b0;
        b0.reg_write_in = 0; b0.mem_read_in = 0; b0.mem_write_in = 0; b0.mem_to_reg_in = 0;
        b0.load_mode_in = 0; b0.wb_dest_in = 0; b0.alu_result_in = 0; b0.rt_in = 0;
        b0.branch_in = 0; b0.zero_in = 0; b0.branch_target_in = 0;
        bw2.reg_write_in = 0; bw2.mem_read_in = 0; bw2.mem_write_in = 0; bw2.mem_to_reg_in = 0;
        bw2.load_mode_in = 0; bw2.wb_dest_in = 0; bw2.alu_result_in = 0; bw2.rt_in = 0;
        bw2.branch_in = 0; bw2.zero_in = 0; bw2.branch_target_in = 0;
        bw3.reg_write_in = 0; bw3.mem_read_in = 0; bw3.mem_write_in = 0; bw3.mem_to_reg_in = 0;
        bw3.load_mode_in = 0; bw3.wb_dest_in = 0; bw3.alu_result_in = 0; bw3.rt_in = 0;
        bw3.branch_in = 0; bw3.zero_in = 0; bw3.branch_target_in = 0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst.data", b0.MEM_WB_read_data, 32'd0);
        check("rst.alu",  b0.MEM_WB_alu_result, 32'd0);
        check("rst.ctl",  ctl(b0.misalign, b0.MEM_WB_RegWrite, b0.MEM_WB_MemToReg,
                              b0.MEM_WB_wb_dest), 32'd0);
        check("rst.stall", 32'(bw2.stall), 32'd0);
        @(negedge CLK); rst_n = 1'b1; rst3_n = 1'b1;
        @(posedge CLK); #1;

        // Single-cycle loads and stores
        issue0("sw8",   0, 0, 1, LOAD_WORD,  32'd8,  32'hDEADBEEF, 32'h0,        0);
        issue0("lw8",   1, 1, 0, LOAD_WORD,  32'd8,  32'h0,        32'hDEADBEEF, 0);
        issue0("lb9",   1, 1, 0, LOAD_BYTE,  32'd9,  32'h0,        32'hFFFFFFBE, 0);
        issue0("lbu9",  1, 1, 0, LOAD_BYTEU, 32'd9,  32'h0,        32'h000000BE, 0);
        issue0("lh10",  1, 1, 0, LOAD_HALF,  32'd10, 32'h0,        32'hFFFFDEAD, 0);
        issue0("sb11",  0, 0, 1, LOAD_BYTE,  32'd11, 32'h12,       32'h0,        0);
        issue0("lw8b",  1, 1, 0, LOAD_WORD,  32'd8,  32'h0,        32'h12ADBEEF, 0);
        issue0("sh8",   0, 0, 1, LOAD_HALF,  32'd8,  32'h5555,     32'h0,        0);
        issue0("lw8c",  1, 1, 0, LOAD_WORD,  32'd8,  32'h0,        32'h12AD5555, 0);
        issue0("lh10b", 1, 1, 0, LOAD_HALF,  32'd10, 32'h0,        32'h000012AD, 0);
        issue0("alu",   1, 0, 0, LOAD_WORD,  32'h1234, 32'h0,      32'h0,        0);
        issue0("rdwr",  1, 1, 1, LOAD_WORD,  32'd16, 32'hCAFEF00D, 32'h0,        0);
        issue0("lw16",  1, 1, 0, LOAD_WORD,  32'd16, 32'h0,        32'hCAFEF00D, 0);
        issue0("wrap",  1, 1, 0, LOAD_WORD,  32'h408, 32'h0,       32'h12AD5555, 0);
        issue0("lh9",   1, 1, 0, LOAD_HALF,  32'd9,  32'h0,
               ALIGN_CHK ? 32'h0 : 32'h00005555, ALIGN_CHK);
        issue0("sw4",   0, 0, 1, LOAD_WORD,  32'd4,  32'h0BADF00D, 32'h0,        0);
        issue0("sw6",   0, 0, 1, LOAD_WORD,  32'd6,  32'h77777777, 32'h0,        ALIGN_CHK);
        issue0("lw4",   1, 1, 0, LOAD_WORD,  32'd4,  32'h0,
               ALIGN_CHK ? 32'h0BADF00D : 32'h77777777, 0);

        // Branch resolution is purely combinational
        b0.mem_read_in = 0; b0.mem_write_in = 0;
        b0.branch_in = 1; b0.zero_in = 1; b0.branch_target_in = 32'h40;
        #1;
        check("br.pc_src", 32'(b0.pc_src), 32'd1);
        check("br.target", b0.branch_target, 32'h40);
        b0.zero_in = 0;
        #1;
        check("br.nz", 32'(b0.pc_src), 32'd0);
        b0.branch_in = 0;
        @(posedge CLK); #1;

        // Wait-state instance
        issue_w("wsw1", 0, 0, 1, 32'd8, 32'h11223344, 32'h0, 1'b0, 32'h0, 32'h0);
        issue_w("wsw2", 0, 0, 1, 32'd8, 32'hA5A5A5A5, 32'h0, 1'b1, 32'h11223344, 32'hA5A5A5A5);
        issue_w("wlw",  1, 1, 0, 32'd8, 32'h0, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h0);
        bw2.mem_read_in = 0; bw2.mem_write_in = 0; bw2.reg_write_in = 0;

        // Reset during a 3-wait store
        bw3.mem_write_in = 1; bw3.load_mode_in = LOAD_WORD; bw3.alu_result_in = 32'd4;
        bw3.rt_in = 32'h11111111; bw3.wb_dest_in = 5'd7;
        repeat (4) @(posedge CLK);
        #1;
        check("w3.sw1.alu", bw3.MEM_WB_alu_result, 32'd4);
        bw3.rt_in = 32'h22222222;
        @(posedge CLK); #2;
        check("w3.busy", 32'(bw3.stall), 32'd1);
        rst3_n = 1'b0;
        #1;
        check("w3.rst.stall", 32'(bw3.stall), 32'd0);
        check("w3.rst.alu",   bw3.MEM_WB_alu_result, 32'd0);
        check("w3.rst.ctl",   ctl(bw3.misalign, bw3.MEM_WB_RegWrite, bw3.MEM_WB_MemToReg,
                                  bw3.MEM_WB_wb_dest), 32'd0);
        repeat (2) @(posedge CLK);
        bw3.mem_write_in = 0;
        @(negedge CLK); rst3_n = 1'b1;
        check("w3.word", u3.u_mem.mem[1], 32'h11111111);
        @(posedge CLK); #1;
        bw3.mem_read_in = 1; bw3.reg_write_in = 1; bw3.mem_to_reg_in = 1;
        repeat (4) @(posedge CLK);
        #1;
        check("w3.lw", bw3.MEM_WB_read_data, 32'h11111111);
        bw3.mem_read_in = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
